mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU requests via a START/BUSY/DONE handshake from the execute control.
- Computes over 32 iterations and holds results in architectural HI/LO registers, read by MFHI/MFLO and written directly by MTHI/MTLO.

Parameters:
- WIDTH, 32, operand/result width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of RUN-state iterations (one bit per cycle).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  request strobe; sampled only when BUSY=0.
- MDOP  in  2  mdop_t: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3.
- PORTA  in  WIDTH  multiplicand/dividend (rs).
- PORTB  in  WIDTH  multiplier/divisor (rt).
- FLUSH  in  1  pipeline squash; aborts an in-flight operation.
- HIWEN  in  1  MTHI write enable.
- LOWEN  in  1  MTLO write enable.
- WDATA  in  WIDTH  MTHI/MTLO data.
- BUSY  out  1  operation in flight; the hazard unit stalls MFHI/MFLO/new md ops while high.
- DONE  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- DIVZ  out  1  with DONE: the finished divide had a zero divisor.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset: RST=1 asynchronously forces state IDLE, HI=0, LO=0, BUSY=0, DONE=0, DIVZ=0, and clears internal accumulators.
- States: IDLE, RUN, FIX, FIN.
- BUSY=1 in RUN and FIX. DONE=1 only in FIN.
- IDLE or FIN, with START=1 and FLUSH=0 at edge 0:
  - Latch MDOP.
  - For signed ops, latch operand magnitudes and the signs of A and B.
  - Clear the iteration counter.
  - Go to RUN.
  - Back-to-back START in FIN is accepted.
- RUN: one iteration per edge, ITER edges (edges 1..32).
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter 0..ITER-1; leave RUN when the counter reaches ITER-1.
- FIX, at edge 33:
  - Apply sign correction.
  - Write HI/LO.
  - Go to FIN.
- FIN: DONE=1 for exactly one cycle, BUSY=0; next state is IDLE unless a new START is accepted.
- Latency: START at edge 0 gives DONE=1 in the cycle after edge 33; fixed for all ops, including divide-by-zero.
- Result rules:
  - MULTU: {HI,LO} = unsigned 64-bit A*B.
  - MULT: {HI,LO} = two's-complement 64-bit A*B; product negated when sign(A)^sign(B).
  - DIVU: LO = A/B, HI = A%B.
  - DIV: truncating division. Quotient negated when sign(A)^sign(B); remainder takes the sign of A.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps silently, no flag).
  - Divisor 0 (DIV or DIVU): LO=0xFFFFFFFF, HI=PORTA as latched; DIVZ=1 in the FIN cycle.
- DIVZ is 0 in every cycle except a FIN cycle for a zero-divisor divide.
- Operands are latched at START; later PORTA/PORTB changes have no effect.
- START while BUSY=1 is ignored (no queueing).
- FLUSH:
  - In RUN or FIX: next edge returns to IDLE, HI/LO unchanged, DONE never pulses.
  - FLUSH with START in IDLE/FIN: START is ignored.
  - FLUSH in FIN: DONE still reads 1 that cycle; the result is already committed.
- HIWEN/LOWEN:
  - Honoured only when BUSY=0; write WDATA at the edge.
  - Ignored while BUSY=1.
  - Same edge as an accepted START: the write applies, then FIX later overwrites it.
- RST mid-operation: immediate abort to the reset state.

Decomposition:
- cpu_types_pkg gains mdop_t (2-bit enum, values above) and mdstate_t (IDLE, RUN, FIX, FIN).
- Single module. The control FSM and the shared shift datapath are tightly coupled, so no sub-module.
- An optional mdu_if interface mirrors the port list with modports mdu and ex.

Test Plan:
- Reset/latency: RST pulse, then MULTU A=7 B=6 at edge 0 -> BUSY edges 1..33, DONE in cycle after edge 33, HI=0, LO=42; HI=LO=0 during reset.
- MULT signed: A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV signs: A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100 B=7 -> LO=14, HI=2. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Divide by zero: DIVU A=0x1234 B=0 -> LO=0xFFFFFFFF, HI=0x1234, DIVZ=1 with DONE only.
- FLUSH/ignore: START MULTU, FLUSH at edge 10 -> IDLE, HI/LO unchanged, no DONE; START at edge 5 while BUSY -> ignored, original result returned.
- MTHI/MTLO: HIWEN=1 WDATA=0xA5A5A5A5 while BUSY -> HI unchanged; same write when idle -> HI=0xA5A5A5A5. Back-to-back START in FIN -> second DONE exactly 34 cycles later.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: multiply/divide opcode and sequencer state encodings.
// Pure declarations, no timing.
// Opcode helpers decode operation class so callers never compare raw bits.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdop_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_FIN  = 2'd3
  } mdstate_t;

  // Divide ops occupy the upper half of the opcode space.
  function automatic logic md_is_div(input mdop_t op);
    return op[1];
  endfunction

  // MULT and DIV are the signed variants (even opcodes).
  function automatic logic md_is_signed(input mdop_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Latency: START at edge 0 -> HI/LO written at edge ITER+1, DONE high the following cycle.
// Backpressure: BUSY high while in flight; START and MTHI/MTLO writes are ignored while BUSY.
module mult_div_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  mdop_t            MDOP,
  input  logic [WIDTH-1:0] PORTA,
  input  logic [WIDTH-1:0] PORTB,
  input  logic             FLUSH,
  input  logic             HIWEN,
  input  logic             LOWEN,
  input  logic [WIDTH-1:0] WDATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIVZ,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // Sequencer state and latched operation context
  mdstate_t         state;
  mdop_t            op_q;
  logic             sign_a;
  logic             sign_b;
  logic             bzero;
  logic [CW-1:0]    cnt;
  // Multiply: opnd = |A|; divide: opnd = |B|
  logic [WIDTH-1:0] opnd;
  // Shared shift register: {upper W+1 bits = partial product / remainder, lower W bits = multiplier / quotient}
  logic [2*WIDTH:0] acc;

  // Request decode
  logic             accept;
  logic             sa_in;
  logic             sb_in;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;

  // One-iteration datapath results
  logic [WIDTH:0]   hi_sum;
  logic [2*WIDTH:0] mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH:0]   rem_new;
  logic [2*WIDTH:0] div_next;

  // Sign-corrected results
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Decode an incoming request into operand magnitudes and sign flags
  always_comb begin
    accept   = START && !FLUSH && ((state == MD_IDLE) || (state == MD_FIN));
    sa_in    = md_is_signed(MDOP) && PORTA[WIDTH-1];
    sb_in    = md_is_signed(MDOP) && PORTB[WIDTH-1];
    a_mag_in = sa_in ? -PORTA : PORTA;
    b_mag_in = sb_in ? -PORTB : PORTB;
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  always_comb begin
    hi_sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      hi_sum = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
    end
    mul_next = {1'b0, hi_sum, acc[WIDTH-1:1]};

    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = {1'b0, rem_sh} - {2'b00, opnd};
    ge       = ~diff[WIDTH+1];
    rem_new  = ge ? diff[WIDTH:0] : rem_sh;
    div_next = {rem_new, acc[WIDTH-2:0], ge};
  end

  // Sign correction of the unsigned magnitude results
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM, iteration datapath and HI/LO registers with registered status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= MD_IDLE;
      op_q   <= MD_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      bzero  <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
      HI     <= '0;
      LO     <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      DIVZ   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      DIVZ <= 1'b0;

      // MTHI/MTLO only land while idle; a START on the same edge still wins later at FIX
      if (!BUSY) begin
        if (HIWEN) HI <= WDATA;
        if (LOWEN) LO <= WDATA;
      end

      case (state)
        MD_IDLE, MD_FIN: begin
          if (accept) begin
            state  <= MD_RUN;
            BUSY   <= 1'b1;
            op_q   <= MDOP;
            sign_a <= sa_in;
            sign_b <= sb_in;
            bzero  <= (PORTB == '0);
            cnt    <= '0;
            if (md_is_div(MDOP)) begin
              opnd <= b_mag_in;
              acc  <= {{(WIDTH+1){1'b0}}, a_mag_in};
            end else begin
              opnd <= a_mag_in;
              acc  <= {{(WIDTH+1){1'b0}}, b_mag_in};
            end
          end else begin
            state <= MD_IDLE;
          end
        end

        MD_RUN: begin
          if (FLUSH) begin
            state <= MD_IDLE;
            BUSY  <= 1'b0;
          end else begin
            acc <= md_is_div(op_q) ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= MD_FIX;
            end
          end
        end

        MD_FIX: begin
          state <= MD_FIN;
          BUSY  <= 1'b0;
          if (FLUSH) begin
            state <= MD_IDLE;
          end else if (md_is_div(op_q)) begin
            // A zero divisor leaves |A| in the remainder, so rem_fix already restores A
            HI   <= rem_fix;
            LO   <= bzero ? '1 : quo_fix;
            DONE <= 1'b1;
            DIVZ <= bzero;
          end else begin
            {HI, LO} <= prod_fix;
            DONE     <= 1'b1;
          end
        end

        default: begin
          state <= MD_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops vs. an arithmetic model.
// Checks latency, BUSY/DONE/DIVZ framing, HI/LO results, FLUSH, ignored START and MTHI/MTLO.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_mult_div_unit;
  import cpu_types_pkg::*;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  mdop_t         MDOP;
  logic [W-1:0]  PORTA;
  logic [W-1:0]  PORTB;
  logic          FLUSH;
  logic          HIWEN;
  logic          LOWEN;
  logic [W-1:0]  WDATA;
  logic          BUSY;
  logic          DONE;
  logic          DIVZ;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  exp_hi = '0;
  logic [W-1:0]  exp_lo = '0;

  always #5 CLK = ~CLK;

  mult_div_unit #(.WIDTH(W), .ITER(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MDOP(MDOP), .PORTA(PORTA), .PORTB(PORTB),
    .FLUSH(FLUSH), .HIWEN(HIWEN), .LOWEN(LOWEN), .WDATA(WDATA),
    .BUSY(BUSY), .DONE(DONE), .DIVZ(DIVZ), .HI(HI), .LO(LO)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Architectural result {divz, HI, LO} from plain 64-bit arithmetic
  function automatic logic [64:0] ref_md(input mdop_t op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic        dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p  = '0;
    case (op)
      MD_MULTU: p = {32'd0, a} * {32'd0, b};
      MD_MULT:  p = 64'(sa * sb);
      MD_DIVU: begin
        if (b == 0) begin dz = 1'b1; p = {a, 32'hFFFF_FFFF}; end
        else        p = {a % b, a / b};
      end
      default: begin
        if (b == 0) begin dz = 1'b1; p = {a, 32'hFFFF_FFFF}; end
        else        p = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return {dz, p};
  endfunction

  // Issue one op (START now), optionally poke START/HIWEN mid-flight, and check the outcome
  task automatic do_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                       input int start_poke, input int hiwen_poke, input bit stay_fin,
                       input string tag);
    logic [64:0] r;
    int          cyc;
    bit          busy_ok;
    bit          quiet_ok;
    bit          hold_ok;
    r = ref_md(op, a, b);
    MDOP  = op;
    PORTA = a;
    PORTB = b;
    START = 1'b1;
    tick();
    START = 1'b0;
    PORTA = $urandom;
    PORTB = $urandom;
    MDOP  = mdop_t'($urandom_range(0, 3));
    cyc = 0; busy_ok = 1; quiet_ok = 1; hold_ok = 1;
    while (!DONE && cyc < 100) begin
      if (!BUSY) busy_ok = 0;
      if (DIVZ) quiet_ok = 0;
      if (HI !== exp_hi || LO !== exp_lo) hold_ok = 0;
      START = (cyc == start_poke);
      HIWEN = (cyc == hiwen_poke);
      LOWEN = (cyc == hiwen_poke);
      WDATA = 32'hA5A5_A5A5;
      tick();
      cyc++;
    end
    START = 1'b0; HIWEN = 1'b0; LOWEN = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'd33);
    chk({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
    chk({tag, "_divz_quiet"}, 64'(quiet_ok), 64'd1);
    chk({tag, "_hilo_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_busy_fin"}, 64'(BUSY), 64'd0);
    chk({tag, "_hi"}, 64'(HI), 64'(r[63:32]));
    chk({tag, "_lo"}, 64'(LO), 64'(r[31:0]));
    chk({tag, "_divz"}, 64'(DIVZ), 64'(r[64]));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    if (!stay_fin) begin
      tick();
      chk({tag, "_done_pulse"}, {62'd0, DONE, DIVZ}, 64'd0);
    end
  endtask

  initial begin
    mdop_t        rop;
    logic [31:0]  ra;
    logic [31:0]  rb;
    bit           saw_done;

    RST = 1'b1; START = 1'b0; MDOP = MD_MULT; PORTA = '0; PORTB = '0;
    FLUSH = 1'b0; HIWEN = 1'b0; LOWEN = 1'b0; WDATA = '0;
    tick();
    HIWEN = 1'b1; LOWEN = 1'b1; WDATA = 32'hDEAD_BEEF;
    tick();
    chk("reset_outputs", {59'd0, BUSY, DONE, DIVZ, 2'b00}, 64'd0);
    chk("reset_hilo", {HI, LO}, 64'd0);
    HIWEN = 1'b0; LOWEN = 1'b0;
    RST = 1'b0;
    tick();

    // Directed corner cases
    do_op(MD_MULTU, 32'd7,          32'd6,          -1, -1, 0, "multu_7x6");
    do_op(MD_MULT,  32'hFFFF_FFFD,  32'd5,          -1, -1, 0, "mult_neg3x5");
    do_op(MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  -1, -1, 0, "multu_max");
    do_op(MD_DIV,   32'hFFFF_FFF9,  32'd2,          -1, -1, 0, "div_neg7_2");
    do_op(MD_DIVU,  32'd100,        32'd7,          -1, -1, 0, "divu_100_7");
    do_op(MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  -1, -1, 0, "div_ovf");
    do_op(MD_DIVU,  32'h0000_1234,  32'd0,          -1, -1, 0, "divu_zero");
    do_op(MD_DIV,   32'hFFFF_FFFB,  32'd0,          -1, -1, 0, "div_neg_zero");
    do_op(MD_DIV,   32'd7,          32'hFFFF_FFFE,  -1, -1, 0, "div_7_neg2");

    // START and HIWEN/LOWEN while busy are ignored
    do_op(MD_MULTU, 32'd1000,       32'd3,           4, -1, 0, "start_busy");
    do_op(MD_DIVU,  32'd55,         32'd9,          -1, 10, 0, "mthi_busy");

    // FLUSH at edge 10 aborts; no DONE and HI/LO keep the previous result
    MDOP = MD_MULTU; PORTA = 32'd9; PORTB = 32'd9; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (9) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_busy", 64'(BUSY), 64'd0);
    saw_done = 0;
    repeat (40) begin
      tick();
      if (DONE) saw_done = 1;
    end
    chk("flush_no_done", 64'(saw_done), 64'd0);
    chk("flush_hilo", {HI, LO}, {exp_hi, exp_lo});

    // FLUSH together with START in IDLE drops the request
    MDOP = MD_MULTU; START = 1'b1; FLUSH = 1'b1;
    tick();
    START = 1'b0; FLUSH = 1'b0;
    chk("flush_start_idle", 64'(BUSY), 64'd0);

    // MTHI / MTLO while idle
    HIWEN = 1'b1; WDATA = 32'hA5A5_A5A5;
    tick();
    HIWEN = 1'b0;
    exp_hi = 32'hA5A5_A5A5;
    chk("mthi_idle", 64'(HI), 64'(exp_hi));
    LOWEN = 1'b1; WDATA = 32'h5A5A_0F0F;
    tick();
    LOWEN = 1'b0;
    exp_lo = 32'h5A5A_0F0F;
    chk("mtlo_idle", {HI, LO}, {exp_hi, exp_lo});

    // Back-to-back: second START issued in the FIN cycle of the first
    do_op(MD_MULT,  32'h0001_0000,  32'hFFFF_0000,  -1, -1, 1, "b2b_first");
    do_op(MD_DIV,   32'hFFFF_FF00,  32'd16,         -1, -1, 0, "b2b_second");

    // Randomized ops against the model
    for (int i = 0; i < 24; i++) begin
      rop = mdop_t'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if (i % 4 == 1) rb = $urandom_range(1, 15);
      if (i % 4 == 2) ra = $urandom_range(0, 1000);
      do_op(rop, ra, rb, -1, -1, 0, "rnd");
    end

    // Asynchronous reset mid-operation
    MDOP = MD_MULTU; PORTA = 32'd123; PORTB = 32'd456; START = 1'b1;
    tick();
    START = 1'b0;
    repeat (5) tick();
    RST = 1'b1;
    #2;
    chk("arst_status", {61'd0, BUSY, DONE, DIVZ}, 64'd0);
    chk("arst_hilo", {HI, LO}, 64'd0);
    tick();
    RST = 1'b0;
    repeat (40) tick();
    chk("arst_stays_idle", {61'd0, BUSY, DONE, DIVZ}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
